// File: rtl/accum_frame8.sv
// rtl/accum_frame8.sv - frame accumulator: sums COUNT input beats and emits one frame sum with a carry flag
// Optional feature macro: ACCUM_FRAME8_SAT_EN (saturating addition; default build wraps)
module accum_frame8 #(
  parameter int WIDTH = 8,
  parameter int COUNT = 4
) (
  input  logic             CLK,
  input  logic             ASYNCRESET,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_carry
);

  typedef enum logic {
    ACCUM = 1'b0,
    HOLD  = 1'b1
  } state_t;

  // Beat index that closes a frame; cnt is a fixed 8-bit counter.
  localparam logic [7:0]       LAST_CNT = 8'(COUNT - 1);
  localparam logic [WIDTH-1:0] ACC_MAX  = '1;
  localparam bit               SINGLE   = (COUNT == 1);

  state_t           state_q;
  state_t           state_d;
  logic [WIDTH-1:0] acc_q;
  logic [WIDTH-1:0] acc_d;
  logic [7:0]       cnt_q;
  logic [7:0]       cnt_d;
  logic             carry_q;
  logic             carry_d;

  logic [WIDTH:0]   sum;
  logic             ovf;
  logic [WIDTH-1:0] add_res;

  // One extra bit of sum width captures the overflow of acc + in_data.
  always_comb begin
    sum = {1'b0, acc_q} + {1'b0, in_data};
    ovf = sum[WIDTH];
`ifdef ACCUM_FRAME8_SAT_EN
    // Clamp to all-ones; once saturated, any further nonzero beat overflows
    // again, so the accumulator stays pinned for the rest of the frame.
    add_res = ovf ? ACC_MAX : sum[WIDTH-1:0];
`else
    add_res = sum[WIDTH-1:0];
`endif
  end

  // Next-state, next-register and handshake logic.
  always_comb begin
    state_d   = state_q;
    acc_d     = acc_q;
    cnt_d     = cnt_q;
    carry_d   = carry_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;

    case (state_q)
      ACCUM: begin
        in_ready = 1'b1;
        if (in_valid) begin
          acc_d   = add_res;
          carry_d = carry_q | ovf;
          if (cnt_q == LAST_CNT) begin
            cnt_d   = 8'd0;
            state_d = HOLD;
          end else begin
            cnt_d = cnt_q + 8'd1;
          end
        end
      end

      HOLD: begin
        out_valid = 1'b1;
        // Pass-through lets a new beat enter in the same cycle the frame
        // leaves, so continuous input never sees a bubble.
        in_ready  = out_ready;
        if (out_ready) begin
          carry_d = 1'b0;
          if (in_valid) begin
            // Beat 0 of the next frame starts from an empty accumulator.
            acc_d = in_data;
            if (SINGLE) begin
              cnt_d   = 8'd0;
              state_d = HOLD;
            end else begin
              cnt_d   = 8'd1;
              state_d = ACCUM;
            end
          end else begin
            acc_d   = '0;
            cnt_d   = 8'd0;
            state_d = ACCUM;
          end
        end
      end

      default: begin
        state_d = ACCUM;
      end
    endcase

    // No beat may be taken while reset is asserted.
    if (ASYNCRESET) begin
      in_ready = 1'b0;
    end
  end

  // State and datapath registers; reset discards any partial frame.
  always_ff @(posedge CLK or posedge ASYNCRESET) begin
    if (ASYNCRESET) begin
      state_q <= ACCUM;
      acc_q   <= '0;
      cnt_q   <= 8'd0;
      carry_q <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      carry_q <= carry_d;
    end
  end

  // The frame sum is the accumulator itself; it is frozen while in HOLD.
  assign out_data  = acc_q;
  assign out_carry = carry_q;

endmodule

// File: tb/tb_accum_frame8.sv
// tb/tb_accum_frame8.sv - self-checking bench for accum_frame8 (COUNT=4 and COUNT=1 instances)
module tb_accum_frame8;

  logic       CLK;
  logic       ASYNCRESET;

  logic       in_valid;
  logic       in_ready;
  logic [7:0] in_data;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] out_data;
  logic       out_carry;

  logic       in_valid1;
  logic       in_ready1;
  logic [7:0] in_data1;
  logic       out_valid1;
  logic       out_ready1;
  logic [7:0] out_data1;
  logic       out_carry1;

  int n_cmp;
  int n_err;

  accum_frame8 #(.WIDTH(8), .COUNT(4)) dut (
    .CLK        (CLK),
    .ASYNCRESET (ASYNCRESET),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_data    (in_data),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .out_carry  (out_carry)
  );

  accum_frame8 #(.WIDTH(8), .COUNT(1)) dut1 (
    .CLK        (CLK),
    .ASYNCRESET (ASYNCRESET),
    .in_valid   (in_valid1),
    .in_ready   (in_ready1),
    .in_data    (in_data1),
    .out_valid  (out_valid1),
    .out_ready  (out_ready1),
    .out_data   (out_data1),
    .out_carry  (out_carry1)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  typedef struct packed {
    logic [3:0][7:0] b;
    int              gap;
    logic [7:0]      exp_data;
    logic            exp_carry;
  } vec_t;

  function automatic vec_t mkv(input logic [7:0] b0, input logic [7:0] b1,
                               input logic [7:0] b2, input logic [7:0] b3,
                               input int gap, input logic [7:0] ed, input logic ec);
    vec_t v;
    v.b[0]      = b0;
    v.b[1]      = b1;
    v.b[2]      = b2;
    v.b[3]      = b3;
    v.gap       = gap;
    v.exp_data  = ed;
    v.exp_carry = ec;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Present a beat on the COUNT=4 port and hold it until accepted (bounded).
  task automatic send_beat(input logic [7:0] d);
    int t;
    in_valid = 1'b1;
    in_data  = d;
    t = 0;
    @(negedge CLK);
    while (!in_ready && t < 50) begin
      @(negedge CLK);
      t++;
    end
    if (!in_ready) begin
      n_cmp++;
      n_err++;
      $display("FAIL send_beat timeout: in_ready stayed %0d, expected 1", in_ready);
    end
    @(posedge CLK);
    #1;
    in_valid = 1'b0;
  endtask

  vec_t vecs[6];

  initial begin
    n_cmp      = 0;
    n_err      = 0;
    ASYNCRESET = 1'b1;
    in_valid   = 1'b0;
    in_data    = 8'd0;
    out_ready  = 1'b1;
    in_valid1  = 1'b0;
    in_data1   = 8'd0;
    out_ready1 = 1'b1;

`ifdef ACCUM_FRAME8_SAT_EN
    vecs[0] = mkv(8'd1,   8'd2,   8'd3,  8'd4,  0, 8'd10,  1'b0);
    vecs[1] = mkv(8'd200, 8'd100, 8'd0,  8'd0,  0, 8'd255, 1'b1);
    vecs[2] = mkv(8'd10,  8'd20,  8'd30, 8'd40, 2, 8'd100, 1'b0);
    vecs[3] = mkv(8'd255, 8'd1,   8'd0,  8'd0,  0, 8'd255, 1'b1);
    vecs[4] = mkv(8'd250, 8'd10,  8'd1,  8'd0,  1, 8'd255, 1'b1);
    vecs[5] = mkv(8'd128, 8'd64,  8'd32, 8'd16, 0, 8'd240, 1'b0);
`else
    vecs[0] = mkv(8'd1,   8'd2,   8'd3,  8'd4,  0, 8'd10,  1'b0);
    vecs[1] = mkv(8'd200, 8'd100, 8'd0,  8'd0,  0, 8'd44,  1'b1);
    vecs[2] = mkv(8'd10,  8'd20,  8'd30, 8'd40, 2, 8'd100, 1'b0);
    vecs[3] = mkv(8'd255, 8'd1,   8'd0,  8'd0,  0, 8'd0,   1'b1);
    vecs[4] = mkv(8'd250, 8'd10,  8'd1,  8'd0,  1, 8'd5,   1'b1);
    vecs[5] = mkv(8'd128, 8'd64,  8'd32, 8'd16, 0, 8'd240, 1'b0);
`endif

    // Reset state.
    #1;
    check("rst in_ready",  in_ready,  0);
    check("rst out_valid", out_valid, 0);
    check("rst out_data",  out_data,  0);
    check("rst out_carry", out_carry, 0);
    check("rst in_ready1", in_ready1, 0);
    repeat (2) @(posedge CLK);
    @(negedge CLK);
    ASYNCRESET = 1'b0;
    @(posedge CLK);
    #1;

    // Table-driven frames with out_ready held high.
    for (int i = 0; i < 6; i++) begin
      for (int j = 0; j < 4; j++) begin
        if (j > 0) begin
          repeat (vecs[i].gap) begin
            @(negedge CLK);
            check($sformatf("v%0d idle out_valid", i), out_valid, 0);
            @(posedge CLK);
            #1;
          end
        end
        send_beat(vecs[i].b[j]);
        if (j == 2) check($sformatf("v%0d early out_valid", i), out_valid, 0);
      end
      check($sformatf("v%0d out_valid", i), out_valid, 1);
      check($sformatf("v%0d out_data", i),  out_data,  vecs[i].exp_data);
      check($sformatf("v%0d out_carry", i), out_carry, vecs[i].exp_carry);
      @(posedge CLK);
      #1;
      check($sformatf("v%0d drained", i), out_valid, 0);
    end

    // Back-pressure: frame held for 5 cycles, then pass-through accept.
    out_ready = 1'b0;
    for (int j = 0; j < 4; j++) send_beat(8'd1);
    in_valid = 1'b1;
    in_data  = 8'd7;
    for (int k = 0; k < 5; k++) begin
      @(negedge CLK);
      check($sformatf("stall%0d in_ready", k),  in_ready,  0);
      check($sformatf("stall%0d out_valid", k), out_valid, 1);
      check($sformatf("stall%0d out_data", k),  out_data,  4);
      @(posedge CLK);
      #1;
    end
    out_ready = 1'b1;
    @(negedge CLK);
    check("release in_ready", in_ready, 1);
    @(posedge CLK);
    #1;
    in_valid = 1'b0;
    check("release out_valid", out_valid, 0);
    for (int j = 0; j < 3; j++) send_beat(8'd1);
    check("after stall out_valid", out_valid, 1);
    check("after stall out_data",  out_data,  10);
    check("after stall out_carry", out_carry, 0);
    @(posedge CLK);
    #1;

    // Asynchronous reset mid-frame.
    send_beat(8'd9);
    send_beat(8'd9);
    #3;
    ASYNCRESET = 1'b1;
    #1;
    check("midrst out_data",  out_data,  0);
    check("midrst out_valid", out_valid, 0);
    check("midrst in_ready",  in_ready,  0);
    #2;
    ASYNCRESET = 1'b0;
    @(posedge CLK);
    #1;
    for (int j = 0; j < 4; j++) send_beat(8'd5);
    check("postrst out_valid", out_valid, 1);
    check("postrst out_data",  out_data,  20);
    check("postrst out_carry", out_carry, 0);
    @(posedge CLK);
    #1;

    // COUNT=1: every beat is a frame, pass-through keeps in_ready high.
    in_valid1 = 1'b1;
    in_data1  = 8'd3;
    @(negedge CLK);
    check("c1 in_ready b0", in_ready1, 1);
    @(posedge CLK);
    #1;
    check("c1 out_valid 3", out_valid1, 1);
    check("c1 out_data 3",  out_data1,  3);
    in_data1 = 8'd4;
    @(negedge CLK);
    check("c1 in_ready b1", in_ready1, 1);
    @(posedge CLK);
    #1;
    check("c1 out_data 4", out_data1, 4);
    in_data1 = 8'd5;
    @(negedge CLK);
    check("c1 in_ready b2", in_ready1, 1);
    @(posedge CLK);
    #1;
    check("c1 out_data 5", out_data1, 5);
    in_valid1 = 1'b0;
    @(posedge CLK);
    #1;
    check("c1 drained", out_valid1, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
